// File: rtl/pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer
//   Elastic in-order buffer that sits between two pipeline stages in place of a
//   fixed stage latch. Carries an opaque DATA_W-bit payload through DEPTH
//   entries with a valid/ready handshake, and adds stall, flush and bubble
//   insertion. Occupancy and saturating drop/bubble counters are exported for
//   the hazard unit and performance monitoring.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   upstream presents in_data
//   in_ready    out  buffer accepts in_data this cycle
//   in_data     in   upstream payload
//   out_valid   out  out_data holds a real entry
//   out_ready   in   downstream consumes this cycle
//   out_data    out  head entry, or BUBBLE_VAL when empty
//   stall       in   freeze the stage (no push, no pop)
//   flush       in   discard all entries at the next edge
//   occupancy   out  number of valid entries
//   drop_cnt    out  entries discarded by flush (saturating)
//   bubble_cnt  out  cycles with out_ready=1 and out_valid=0 (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_buffer #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 2,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       stall,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           bubble_cnt
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + OCC_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Pointer increment with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Saturating add of a small increment onto a statistics counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [OCC_W-1:0] b);
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] res;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            res = {CNT_W{1'b1}};
        end else begin
            res = sum[CNT_W-1:0];
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [OCC_W-1:0]  occ_r;
    logic [CNT_W-1:0]  drop_cnt_r;
    logic [CNT_W-1:0]  bubble_cnt_r;
    // Holds in_ready low while in reset; rises on the first edge after release.
    logic              alive_r;

    logic              out_valid_s;
    logic              out_fire_s;
    logic              in_ready_s;
    logic              in_fire_s;
    logic [DATA_W-1:0] out_data_s;

    // Handshake decode; in_ready sees out_ready only through out_fire, which
    // matters only when the buffer is full.
    always_comb begin
        out_valid_s = 1'b0;
        out_fire_s  = 1'b0;
        in_ready_s  = 1'b0;
        in_fire_s   = 1'b0;
        out_valid_s = (occ_r != {OCC_W{1'b0}}) & ~stall & ~flush;
        out_fire_s  = out_valid_s & out_ready;
        in_ready_s  = alive_r & ~stall & ~flush & ((occ_r < OCC_FULL) | out_fire_s);
        in_fire_s   = in_valid & in_ready_s;
    end

    // Head selection; empty buffer presents the bubble encoding.
    always_comb begin
        out_data_s = BUBBLE_VAL;
        if (occ_r != {OCC_W{1'b0}}) begin
            out_data_s = mem_r[rd_ptr_r];
        end else begin
            out_data_s = BUBBLE_VAL;
        end
    end

    // Payload storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers, occupancy and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            occ_r        <= {OCC_W{1'b0}};
            drop_cnt_r   <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
            alive_r      <= 1'b0;
        end else begin
            alive_r <= 1'b1;
            if (out_ready && !out_valid_s) begin
                bubble_cnt_r <= sat_add(bubble_cnt_r, OCC_W'(1));
            end
            if (flush) begin
                // A held flush finds occ_r already zero, so it adds nothing.
                rd_ptr_r   <= {PTR_W{1'b0}};
                wr_ptr_r   <= {PTR_W{1'b0}};
                occ_r      <= {OCC_W{1'b0}};
                drop_cnt_r <= sat_add(drop_cnt_r, occ_r);
            end else begin
                if (in_fire_s) begin
                    wr_ptr_r <= ptr_next(wr_ptr_r);
                end
                if (out_fire_s) begin
                    rd_ptr_r <= ptr_next(rd_ptr_r);
                end
                case ({in_fire_s, out_fire_s})
                    2'b10:   occ_r <= occ_r + OCC_W'(1);
                    2'b01:   occ_r <= occ_r - OCC_W'(1);
                    default: occ_r <= occ_r;
                endcase
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign out_data   = out_data_s;
    assign occupancy  = occ_r;
    assign drop_cnt   = drop_cnt_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buffer
//   Scoreboard bench for pipe_stage_buffer. Instance A: DEPTH=2, bubble 0x13.
//   Instance B: DEPTH=3, CNT_W=4. Stimulus pushes expected payloads into a
//   per-instance queue; negedge monitors pop and compare on every out_fire.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buffer;

    logic clk;
    logic rst_n;

    // Instance A signals
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall, a_flush;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_drop, a_bubble;

    // Instance B signals
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall, b_flush;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_drop, b_bubble;

    int n_cmp;
    int n_err;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    pipe_stage_buffer #(
        .DATA_W(32), .DEPTH(2), .BUBBLE_VAL(32'h00000013), .CNT_W(16)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .stall(a_stall), .flush(a_flush),
        .occupancy(a_occ), .drop_cnt(a_drop), .bubble_cnt(a_bubble)
    );

    pipe_stage_buffer #(
        .DATA_W(32), .DEPTH(3), .BUBBLE_VAL(32'h00000000), .CNT_W(4)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .stall(b_stall), .flush(b_flush),
        .occupancy(b_occ), .drop_cnt(b_drop), .bubble_cnt(b_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: every delivered entry must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            n_cmp++;
            if (exp_a.size() == 0) begin
                n_err++;
                $display("FAIL a_unexpected_out: got 0x%0h, expected no delivery", a_out_data);
            end else begin
                logic [31:0] e;
                e = exp_a.pop_front();
                if (a_out_data !== e) begin
                    n_err++;
                    $display("FAIL a_out_data: got 0x%0h, expected 0x%0h", a_out_data, e);
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            n_cmp++;
            if (exp_b.size() == 0) begin
                n_err++;
                $display("FAIL b_unexpected_out: got 0x%0h, expected no delivery", b_out_data);
            end else begin
                logic [31:0] e;
                e = exp_b.pop_front();
                if (b_out_data !== e) begin
                    n_err++;
                    $display("FAIL b_out_data: got 0x%0h, expected 0x%0h", b_out_data, e);
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = 32'h0; a_out_ready = 1'b0; a_stall = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = 32'h0; b_out_ready = 1'b0; b_stall = 1'b0; b_flush = 1'b0;

        // ---------------- reset ----------------
        #23;
        chk("rst_out_valid", {31'b0, a_out_valid}, 32'h0);
        chk("rst_out_data", a_out_data, 32'h00000013);
        chk("rst_occ", {30'b0, a_occ}, 32'h0);
        chk("rst_drop", {16'b0, a_drop}, 32'h0);
        chk("rst_bubble", {16'b0, a_bubble}, 32'h0);
        chk("rst_in_ready", {31'b0, a_in_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", {31'b0, a_in_ready}, 32'h1);
        chk("post_rst_out_data", a_out_data, 32'h00000013);

        // ---------------- streaming 1..4 ----------------
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1'b1; a_in_data = 32'(i); a_out_ready = 1'b1;
            exp_a.push_back(32'(i));
            step();
            chk("stream_occ", {30'b0, a_occ}, 32'h1);
        end
        a_in_valid = 1'b0;
        step();
        a_out_ready = 1'b0;
        chk("stream_bubble", {16'b0, a_bubble}, 32'h1);
        chk("stream_drained_occ", {30'b0, a_occ}, 32'h0);

        // ---------------- backpressure ----------------
        a_in_valid = 1'b1; a_in_data = 32'hA; exp_a.push_back(32'hA);
        step();
        a_in_data = 32'hB; exp_a.push_back(32'hB);
        step();
        a_in_data = 32'hC;
        #1;
        chk("bp_full_occ", {30'b0, a_occ}, 32'h2);
        chk("bp_full_in_ready", {31'b0, a_in_ready}, 32'h0);
        a_out_ready = 1'b1;
        #1;
        chk("bp_push_pop_full_in_ready", {31'b0, a_in_ready}, 32'h1);
        exp_a.push_back(32'hC);
        step();
        chk("bp_push_pop_occ", {30'b0, a_occ}, 32'h2);
        a_in_valid = 1'b0;
        step();
        step();
        a_out_ready = 1'b0;
        chk("bp_drained_occ", {30'b0, a_occ}, 32'h0);

        // ---------------- flush at occupancy 2 ----------------
        a_in_valid = 1'b1; a_in_data = 32'h11;
        step();
        a_in_data = 32'h22;
        step();
        a_in_data = 32'h33; a_flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'b0, a_in_ready}, 32'h0);
        chk("flush_out_valid", {31'b0, a_out_valid}, 32'h0);
        step();
        chk("flush_occ", {30'b0, a_occ}, 32'h0);
        chk("flush_drop", {16'b0, a_drop}, 32'h2);
        step();
        chk("flush2_drop", {16'b0, a_drop}, 32'h2);
        a_flush = 1'b0; a_in_valid = 1'b0;
        step();
        chk("flush_push_rejected_occ", {30'b0, a_occ}, 32'h0);
        chk("flush_out_data_bubble", a_out_data, 32'h00000013);

        // ---------------- stall 3 cycles at occupancy 1 ----------------
        a_in_valid = 1'b1; a_in_data = 32'h55; exp_a.push_back(32'h55);
        step();
        a_in_valid = 1'b0; a_stall = 1'b1; a_out_ready = 1'b1;
        #1;
        chk("stall_out_valid", {31'b0, a_out_valid}, 32'h0);
        chk("stall_in_ready", {31'b0, a_in_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_occ", {30'b0, a_occ}, 32'h1);
            chk("stall_head", a_out_data, 32'h55);
        end
        a_stall = 1'b0;
        chk("stall_bubble", {16'b0, a_bubble}, 32'h4);
        step();
        a_out_ready = 1'b0;
        chk("stall_release_occ", {30'b0, a_occ}, 32'h0);
        chk("a_scoreboard_empty", 32'(exp_a.size()), 32'h0);

        // ---------------- DEPTH=3 wrap and saturation ----------------
        b_in_valid = 1'b1; b_in_data = 32'h100; exp_b.push_back(32'h100);
        step();
        b_in_data = 32'h101; exp_b.push_back(32'h101);
        step();
        chk("b_fill_occ", {30'b0, b_occ}, 32'h2);
        b_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b_in_data = 32'h102 + 32'(i);
            exp_b.push_back(32'h102 + 32'(i));
            step();
            chk("b_steady_occ", {30'b0, b_occ}, 32'h2);
        end
        b_in_valid = 1'b0;
        step();
        step();
        chk("b_drained_occ", {30'b0, b_occ}, 32'h0);
        chk("b_bubble_zero", {28'b0, b_bubble}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        chk("b_bubble_sat", {28'b0, b_bubble}, 32'hF);
        chk("b_out_data_bubble", b_out_data, 32'h0);
        b_out_ready = 1'b0;
        chk("b_scoreboard_empty", 32'(exp_b.size()), 32'h0);

        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised elastic pipeline buffer register that replaces fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Carries an opaque packed payload of DATA_W bits, typically one stage struct, through a DEPTH-entry in-order buffer with valid/ready handshake.
- Adds stall, flush and bubble insertion that plain stage latches lack.
- Exposes occupancy and saturating drop/bubble counters for the hazard unit and performance monitoring.

Parameters:
- DATA_W, 32, payload width in bits; set to the $bits of the carried stage struct.
- DEPTH, 2, number of buffer entries (1..8); 1 gives a plain stage register, 2 gives a skid buffer.
- BUBBLE_VAL, '0, DATA_W-bit payload driven on out_data when the buffer is empty (NOP/bubble encoding).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream stage presents in_data.
- in_ready  out  1  buffer accepts in_data this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a real entry.
- out_ready  in  1  downstream stage consumes this cycle.
- out_data  out  DATA_W  head entry, or BUBBLE_VAL when empty.
- stall  in  1  hazard unit freezes the stage.
- flush  in  1  synchronously discard all entries (branch/exception).
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.
- drop_cnt  out  CNT_W  total entries discarded by flush, saturating.
- bubble_cnt  out  CNT_W  cycles where out_ready=1 and out_valid=0, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - occupancy=0 and read/write pointers=0.
  - drop_cnt=0 and bubble_cnt=0.
  - out_valid=0, out_data=BUBBLE_VAL, in_ready=0.
  - Storage contents are don't-care.
  - in_ready may rise in the first cycle after rst_n deasserts.
- Fire definitions:
  - out_fire = out_valid & out_ready.
  - in_fire = in_valid & in_ready.
- out_valid = (occupancy != 0) & ~stall & ~flush.
- out_data = head entry when occupancy != 0, else BUBBLE_VAL. out_data is independent of stall and flush.
- in_ready = ~stall & ~flush & ((occupancy < DEPTH) | out_fire). The path from out_ready to in_ready is combinational only when the buffer is full.
- Latency: 1 cycle minimum, with no empty-buffer bypass. Data pushed at edge N is visible on out_data after edge N.
- Throughput is one entry per cycle at every DEPTH, including DEPTH=1 via push-while-pop when full.
- Ordering:
  - Strict FIFO.
  - Pointers wrap from DEPTH-1 to 0, so non-power-of-2 DEPTH is legal.
  - Simultaneous in_fire and out_fire leaves occupancy unchanged and is legal at full and at any level.
- Stall:
  - No push and no pop; storage, pointers and occupancy hold.
  - out_valid=0 and in_ready=0.
  - bubble_cnt still counts cycles with out_ready=1.
- Flush:
  - Highest priority over stall, in_valid and out_ready.
  - At the edge, occupancy becomes 0 and pointers reset to 0.
  - drop_cnt += occupancy (pre-flush value), saturating at 2^CNT_W-1.
  - No entry is accepted or delivered in the flush cycle.
  - Flush held for several cycles: only the first cycle drops entries.
- bubble_cnt increments (saturating) every cycle with out_ready=1 and out_valid=0, including stall and flush cycles.
- occupancy never exceeds DEPTH and never underflows. A pop while empty cannot occur because out_valid=0.
- Reset asserted mid-operation clears everything immediately. In-flight entries are lost and are not counted in drop_cnt.

Test Plan:
- Reset with DEPTH=2, DATA_W=32, BUBBLE_VAL=32'h00000013:
  - During and after reset: out_valid=0, out_data=32'h00000013, occupancy=0, drop_cnt=bubble_cnt=0.
  - in_ready=0 while rst_n=0 and 1 on the cycle after release.
- Streaming with in_valid=1, out_ready=1, payloads 1,2,3,4:
  - Each payload appears one cycle after it is pushed, one per cycle, in order.
  - occupancy stays at 1.
  - bubble_cnt=1 from the initial empty cycle.
- Backpressure with out_ready=0, pushing 0xA, 0xB, 0xC:
  - 0xA and 0xB are accepted; in_ready=0 at occupancy=2.
  - Raising out_ready gives 0xA, then 0xB, then 0xC with no loss.
  - At full with out_ready=1, a new push is accepted in the same cycle.
- Flush with occupancy=2:
  - Next cycle: occupancy=0, out_valid=0, drop_cnt=2.
  - A second consecutive flush cycle leaves drop_cnt=2.
  - A push asserted during flush is not accepted.
- Stall for 3 cycles with occupancy=1 and out_ready=1:
  - out_valid=0, in_ready=0, head and occupancy unchanged.
  - bubble_cnt increments by 3.
  - After stall drops, the head is delivered next cycle.
- DEPTH=3 with CNT_W=4:
  - 10 push/pop cycles with occupancy=2 steady wrap the pointers and keep FIFO order.
  - 20 empty cycles with out_ready=1 saturate bubble_cnt at 15.
